// File: rtl/mul_hilo_seq_pkg.sv
// rtl/mul_hilo_seq_pkg.sv - shared sequencer state encoding and width defaults
//
// Purpose: state encoding and constants shared by the HI/LO multiply
//          sequencer and the future divider sequencer.
// Contents: seq_state_t (IDLE/SETTLE/WRITE), WIDTH_DEF, CNT_W.
package mul_hilo_seq_pkg;

  localparam int WIDTH_DEF = 32;
  // Settle counter width; covers the legal SETTLE_CYCLES range 1..15.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_WRITE  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/mul_hilo_seq_hilo_regs.sv
// rtl/mul_hilo_seq_hilo_regs.sv - HI/LO register pair with load priority and ovf compare
//
// Purpose: holds HI/LO. A multiply write takes priority over direct bus
//          loads. ovf is set from the product and cleared by any direct load.
// Ports:
//   clock, clear       clock and synchronous active-low reset
//   wr_mul             write the product this cycle
//   hi_load, lo_load   direct loads from bus_in (already gated by the caller)
//   bus_in             bus data for direct loads
//   prod               2*WIDTH signed product
//   hi, lo, ovf        register outputs
module hilo_regs #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               wr_mul,
  input  logic               hi_load,
  input  logic               lo_load,
  input  logic [WIDTH-1:0]   bus_in,
  input  logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               ovf
);

  logic [WIDTH-1:0] prod_hi;
  logic [WIDTH-1:0] prod_lo;
  logic             prod_ovf;

  assign prod_hi  = prod[2*WIDTH-1:WIDTH];
  assign prod_lo  = prod[WIDTH-1:0];
  // The product fits in WIDTH signed bits only if HI is the sign extension of LO.
  assign prod_ovf = (prod_hi != {WIDTH{prod_lo[WIDTH-1]}});

  always_ff @(posedge clock) begin
    if (!clear) begin
      hi  <= '0;
      lo  <= '0;
      ovf <= 1'b0;
    end else if (wr_mul) begin
      hi  <= prod_hi;
      lo  <= prod_lo;
      ovf <= prod_ovf;
    end else begin
      if (hi_load) hi <= bus_in;
      if (lo_load) lo <= bus_in;
      if (hi_load || lo_load) ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/mul_hilo_seq.sv
// rtl/mul_hilo_seq.sv - multi-cycle sequencer for the external Booth multiplier
//
// Purpose: captures operands on start, holds them on mul_a/mul_b for
//          SETTLE_CYCLES cycles, then writes mul_p into HI/LO and pulses done.
//          Direct HI/LO loads are accepted only while idle.
// Ports:
//   clock, clear          clock and synchronous active-low reset
//   start, a_in, b_in     multiply request and operands
//   mul_a, mul_b, mul_p   interface to the external alu_mul
//   hi_load, lo_load,
//   bus_in                direct HI/LO loads
//   hi_out, lo_out        HI/LO registers
//   busy, done, ovf       status
module mul_hilo_seq
  import mul_hilo_seq_pkg::*;
#(
  parameter int WIDTH         = WIDTH_DEF,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_p,
  input  logic               hi_load,
  input  logic               lo_load,
  input  logic [WIDTH-1:0]   bus_in,
  output logic [WIDTH-1:0]   hi_out,
  output logic [WIDTH-1:0]   lo_out,
  output logic               busy,
  output logic               done,
  output logic               ovf
);

  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("mul_hilo_seq: SETTLE_CYCLES must be in 1..15");
    end
  endgenerate

  seq_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] a_nxt, b_nxt;
  logic             busy_nxt, done_nxt;
  logic             wr_mul, load_ok;

  always_ff @(posedge clock) begin
    if (!clear) begin
      state <= ST_IDLE;
      cnt   <= '0;
      mul_a <= '0;
      mul_b <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      mul_a <= a_nxt;
      mul_b <= b_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    a_nxt     = mul_a;
    b_nxt     = mul_b;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          a_nxt     = a_in;
          b_nxt     = b_in;
          cnt_nxt   = CNT_W'(SETTLE_CYCLES - 1);
          busy_nxt  = 1'b1;
          state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt == '0) state_nxt = ST_WRITE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      ST_WRITE: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign wr_mul  = (state == ST_WRITE);
  // A start in the same idle cycle does not block a direct load; busy is
  // still low in that cycle, so both take effect.
  assign load_ok = !busy && (state != ST_WRITE);

  hilo_regs #(.WIDTH(WIDTH)) u_hilo_regs (
    .clock   (clock),
    .clear   (clear),
    .wr_mul  (wr_mul),
    .hi_load (hi_load && load_ok),
    .lo_load (lo_load && load_ok),
    .bus_in  (bus_in),
    .prod    (mul_p),
    .hi      (hi_out),
    .lo      (lo_out),
    .ovf     (ovf)
  );

endmodule
